reflex_round_ctrl: RTL and testbench

Game sequencer for the reflex trainer. Runs a fixed number of rounds. Each round waits a pseudo-random delay, places a target ball at a pseudo-random screen position, and waits for a left click. It times the reaction in milliseconds and tallies hits and misses. Its `ball_active`/`ball_x`/`ball_y` outputs feed the ball-region decoder whose `enable_ball` drives the pixel generator; mouse inputs come from the mouse interface in the same clock domain.

---
 rtl/reflex_pkg.sv | 23 ++
 rtl/ms_tick_gen.sv | 27 ++
 rtl/reflex_round_ctrl.sv | 159 +++++++++++++++
 tb/tb_reflex_round_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reflex_pkg.sv
// Shared definitions for the reflex trainer: sequencer states, LFSR constants
// and default timing values.
package reflex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DELAY,
    S_SHOW,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 (1-based) -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_TICK_DIV     = 100000;
  localparam int DEF_DELAY_MIN_MS = 500;
  localparam int DEF_TIMEOUT_MS   = 1500;
  localparam int DEF_BALL_R       = 16;
  localparam int DEF_ROUNDS       = 10;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, counting the
// clear cycle as the first clock of a fresh interval.
module ms_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST  = W'(TICK_DIV - 1);
  localparam logic [W-1:0] FIRST = (TICK_DIV > 1) ? W'(1) : '0;

  logic [W-1:0] r_cnt;

  always_comb tick = clear ? (TICK_DIV == 1) : (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_cnt <= '0;
    else if (clear)        r_cnt <= FIRST;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                   r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/reflex_round_ctrl.sv
// Reflex trainer game sequencer: random delay, random target placement,
// click hit-testing, reaction timing and hit/miss tallies over a fixed round count.
module reflex_round_ctrl
  import reflex_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DELAY_MIN_MS = DEF_DELAY_MIN_MS,
  parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS,
  parameter int BALL_R       = DEF_BALL_R,
  parameter int ROUNDS       = DEF_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        mouse_left,
  output logic        ball_active,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [11:0] rt_ms,
  output logic        rt_valid,
  output logic [3:0]  hits,
  output logic [3:0]  misses,
  output logic        game_done
);

  localparam logic signed [10:0] LP_R  = 11'(BALL_R);
  localparam logic signed [10:0] LP_RN = 11'(-BALL_R);

  state_t       r_state, r_state_d;
  logic [15:0]  r_lfsr;
  logic [15:0]  r_ms_cnt, r_delay_ms;
  logic [9:0]   r_ball_x, r_ball_y;
  logic         r_ball_active, r_rt_valid, r_game_done, r_ml_d;
  logic [11:0]  r_rt_ms;
  logic [3:0]   r_hits, r_misses, r_round_cnt;

  logic         w_entry, w_tick, w_click, w_in_box, w_timeout, w_delay_done;
  logic [15:0]  w_ms_cur, w_ms_next, w_delay_new;
  logic [9:0]   w_x_new, w_y_new;
  logic signed [10:0] w_dx, w_dy;

  // A state change is visible as r_state != r_state_d during the first cycle
  // of the new state; that cycle restarts both prescaler and ms count.
  assign w_entry   = (r_state != r_state_d);
  assign w_ms_cur  = w_entry ? '0 : r_ms_cnt;
  assign w_ms_next = w_ms_cur + 16'd1;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_entry),
    .tick  (w_tick)
  );

  assign w_delay_done = w_tick && (w_ms_next >= r_delay_ms);
  assign w_timeout    = w_tick && (w_ms_next >= 16'(TIMEOUT_MS));
  assign w_click      = mouse_left & ~r_ml_d;

  assign w_dx     = $signed({1'b0, mouse_x}) - $signed({1'b0, r_ball_x});
  assign w_dy     = $signed({1'b0, mouse_y}) - $signed({1'b0, r_ball_y});
  assign w_in_box = (w_dx <= LP_R) && (w_dx >= LP_RN) && (w_dy <= LP_R) && (w_dy >= LP_RN);

  assign w_delay_new = 16'(DELAY_MIN_MS) + {6'b0, r_lfsr[9:0]};
  assign w_x_new     = 10'(BALL_R) + {1'b0, r_lfsr[8:0]};
  assign w_y_new     = 10'(BALL_R) + {2'b0, r_lfsr[15:8]} + {3'b0, r_lfsr[15:9]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_state_d     <= S_IDLE;
      r_lfsr        <= LFSR_SEED;
      r_ms_cnt      <= '0;
      r_delay_ms    <= '0;
      r_ball_x      <= '0;
      r_ball_y      <= '0;
      r_ball_active <= 1'b0;
      r_rt_valid    <= 1'b0;
      r_game_done   <= 1'b0;
      r_ml_d        <= 1'b0;
      r_rt_ms       <= '0;
      r_hits        <= '0;
      r_misses      <= '0;
      r_round_cnt   <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
      r_state_d  <= r_state;
      r_ml_d     <= mouse_left;
      r_ms_cnt   <= w_ms_cur + {15'b0, w_tick};
      r_rt_valid <= 1'b0;
      if (abort) begin
        r_state       <= S_IDLE;
        r_ball_active <= 1'b0;
        r_game_done   <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_state     <= S_WAIT_DELAY;
              r_game_done <= 1'b0;
              r_hits      <= '0;
              r_misses    <= '0;
              r_rt_ms     <= '0;
              r_round_cnt <= '0;
              r_delay_ms  <= w_delay_new;
              r_ball_x    <= w_x_new;
              r_ball_y    <= w_y_new;
            end
          end
          S_WAIT_DELAY: begin
            if (w_delay_done) begin
              r_state       <= S_SHOW;
              r_ball_active <= 1'b1;
            end
          end
          S_SHOW: begin
            if (w_click && w_in_box) begin
              r_state       <= S_RESULT;
              r_ball_active <= 1'b0;
              r_rt_valid    <= 1'b1;
              r_hits        <= r_hits + 4'd1;
              r_round_cnt   <= r_round_cnt + 4'd1;
              r_rt_ms       <= (w_ms_cur > 16'd4095) ? 12'hFFF : w_ms_cur[11:0];
            end else if (w_click || w_timeout) begin
              r_state       <= S_RESULT;
              r_ball_active <= 1'b0;
              r_misses      <= r_misses + 4'd1;
              r_round_cnt   <= r_round_cnt + 4'd1;
            end
          end
          S_RESULT: begin
            if (r_round_cnt == 4'(ROUNDS)) begin
              r_state     <= S_DONE;
              r_game_done <= 1'b1;
            end else begin
              r_state    <= S_WAIT_DELAY;
              r_delay_ms <= w_delay_new;
              r_ball_x   <= w_x_new;
              r_ball_y   <= w_y_new;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ball_active = r_ball_active;
  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign rt_ms       = r_rt_ms;
  assign rt_valid    = r_rt_valid;
  assign hits        = r_hits;
  assign misses      = r_misses;
  assign game_done   = r_game_done;

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Scoreboard bench for reflex_round_ctrl: the driver predicts target placement
// and round outcomes from the game rules; a monitor checks them as they appear.
module tb_reflex_round_ctrl;

  localparam int TD = 4, DMIN = 2, TMO = 8, BR = 16, NR = 3;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, mouse_left = 1'b0;
  logic [9:0]  mouse_x = '0, mouse_y = '0;
  logic        ball_active, rt_valid, game_done;
  logic [9:0]  ball_x, ball_y;
  logic [11:0] rt_ms;
  logic [3:0]  hits, misses;

  always #5 clk = ~clk;

  reflex_round_ctrl #(
    .TICK_DIV(TD), .DELAY_MIN_MS(DMIN), .TIMEOUT_MS(TMO), .BALL_R(BR), .ROUNDS(NR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
    .ball_active(ball_active), .ball_x(ball_x), .ball_y(ball_y),
    .rt_ms(rt_ms), .rt_valid(rt_valid), .hits(hits), .misses(misses),
    .game_done(game_done)
  );

  typedef struct { int unsigned at; int unsigned x; int unsigned y; } show_t;
  typedef struct { int unsigned at; int unsigned rtv; int unsigned h; int unsigned m; int unsigned rt; } res_t;

  show_t q_show[$];
  res_t  q_res[$];
  show_t ms;
  res_t  mr;

  int unsigned cyc = 0;
  int total = 0, bad = 0;
  bit mon_prev = 1'b0;
  int unsigned m_hits, m_misses, m_rt, m_round, m_rise, m_x, m_y;

  // cyc = number of rising edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pseudo-random source value after n clocks from the seed
  function automatic logic [15:0] lfsr_at(input int unsigned n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int unsigned i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  task automatic arm(input int unsigned e, input logic [15:0] v);
    int unsigned d;
    d      = DMIN + v[9:0];
    m_x    = BR + v[8:0];
    m_y    = BR + v[15:8] + v[15:9];
    m_rise = e + d * TD;
    q_show.push_back('{m_rise, m_x, m_y});
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic begin_game();
    int unsigned k;
    @(negedge clk); start = 1'b1; k = cyc;
    @(negedge clk); start = 1'b0;
    m_hits = 0; m_misses = 0; m_rt = 0; m_round = 0;
    chk("start_clr_hits", hits, 0);
    chk("start_clr_misses", misses, 0);
    chk("start_clr_rt", rt_ms, 0);
    chk("start_clr_done", game_done, 0);
    arm(k + 1, lfsr_at(k));
  endtask

  // act: 0 hit, 1 miss-click, 2 timeout, 3 abort
  task automatic do_round(input int act, input int unsigned j, input int dx, input int dy, input bit early);
    int unsigned f, rtv;
    if (early) begin
      @(negedge clk); mouse_left = 1'b1;
      @(negedge clk); mouse_left = 1'b0;
    end
    wait_cyc(m_rise);
    mouse_x = 10'(int'(m_x) + dx);
    mouse_y = 10'(int'(m_y) + dy);
    rtv = 0;
    if (act == 2) begin
      f = m_rise + TMO * TD;
      wait_cyc(f);
    end else begin
      wait_cyc(m_rise + j);
      if (act == 3) abort = 1'b1; else mouse_left = 1'b1;
      f = m_rise + j + 1;
      @(negedge clk); abort = 1'b0; mouse_left = 1'b0;
    end
    if (act == 0) begin m_hits++; m_rt = j / TD; rtv = 1; end
    else if (act != 3) m_misses++;
    q_res.push_back('{f, rtv, m_hits, m_misses, m_rt});
    if (act == 3) begin
      wait_cyc(f + 1);
      chk("abort_game_done", game_done, 0);
      return;
    end
    m_round++;
    if (m_round == NR) begin
      wait_cyc(f + 1);
      chk("game_done", game_done, 1);
    end else arm(f + 1, lfsr_at(f));
  endtask

  task automatic rand_round(input int act);
    int unsigned j;
    int dx, dy, o;
    j  = $urandom_range(TMO * TD - 1, 0);
    dx = int'($urandom_range(2 * BR, 0)) - BR;
    dy = int'($urandom_range(2 * BR, 0)) - BR;
    if (act == 1) begin
      o = BR + 1 + int'($urandom_range(30, 0));
      if ($urandom_range(1, 0) == 1) dx = (m_x >= 64 && $urandom_range(1, 0) == 1) ? -o : o;
      else                           dy = (m_y >= 64 && $urandom_range(1, 0) == 1) ? -o : o;
    end
    do_round(act, j, dx, dy, $urandom_range(1, 0) == 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ball_active && !mon_prev) begin
        if (q_show.size() == 0) begin
          total++; bad++;
          $display("FAIL show_unexpected: got target at cycle %0d expected none", cyc);
        end else begin
          ms = q_show.pop_front();
          chk("show_cycle", cyc, ms.at);
          chk("ball_x", ball_x, ms.x);
          chk("ball_y", ball_y, ms.y);
        end
      end
      if (!ball_active && mon_prev) begin
        if (q_res.size() == 0) begin
          total++; bad++;
          $display("FAIL result_unexpected: got round end at cycle %0d expected none", cyc);
        end else begin
          mr = q_res.pop_front();
          chk("result_cycle", cyc, mr.at);
          chk("rt_valid", rt_valid, mr.rtv);
          chk("hits", hits, mr.h);
          chk("misses", misses, mr.m);
          chk("rt_ms", rt_ms, mr.rt);
        end
      end else if (rt_valid) chk("rt_valid_stray", rt_valid, 0);
    end
    mon_prev = ball_active;
  end

  initial begin
    rst = 1'b1; start = 1'b1;
    #12;
    chk("rst_ball_active", ball_active, 0);
    chk("rst_ball_x", ball_x, 0);
    chk("rst_ball_y", ball_y, 0);
    chk("rst_hits", hits, 0);
    chk("rst_misses", misses, 0);
    chk("rst_rt_ms", rt_ms, 0);
    chk("rst_rt_valid", rt_valid, 0);
    chk("rst_game_done", game_done, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("first_ball_x", ball_x, 241);
    chk("first_ball_y", ball_y, 274);
    m_hits = 0; m_misses = 0; m_rt = 0; m_round = 0;
    arm(1, lfsr_at(0));

    // Game 1: corner hit after 3 ticks, just-outside miss with an early click, timeout
    do_round(0, 12, 16, -16, 1'b0);
    do_round(1, $urandom_range(TMO * TD - 1, 0), 17, 0, 1'b1);
    do_round(2, 0, 0, 0, 1'b0);

    // Game 2 from DONE: hit on the timeout cycle, then random rounds
    begin_game();
    do_round(0, TMO * TD - 1, -16, 16, 1'b0);
    rand_round(int'($urandom_range(2, 0)));
    rand_round(int'($urandom_range(2, 0)));

    // Game 3: hit then abort mid-target; start coinciding with abort is lost
    begin_game();
    rand_round(0);
    do_round(3, $urandom_range(TMO * TD - 1, 0), 0, 0, 1'b0);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("lost_start_hits", hits, m_hits);
    chk("lost_start_misses", misses, m_misses);
    chk("lost_start_active", ball_active, 0);

    // Game 4: asynchronous reset while waiting for the second target
    begin_game();
    rand_round(int'($urandom_range(2, 0)));
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_ball_active", ball_active, 0);
    chk("arst_ball_x", ball_x, 0);
    chk("arst_ball_y", ball_y, 0);
    chk("arst_hits", hits, 0);
    chk("arst_misses", misses, 0);
    chk("arst_rt_ms", rt_ms, 0);
    chk("arst_rt_valid", rt_valid, 0);
    chk("arst_game_done", game_done, 0);
    q_show.delete();
    @(negedge clk); rst = 1'b0;

    // Game 5: fully random after reset
    begin_game();
    for (int i = 0; i < NR; i++) rand_round(int'($urandom_range(2, 0)));

    repeat (4) @(negedge clk);
    chk("show_queue_drained", q_show.size(), 0);
    chk("result_queue_drained", q_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
